// File: rtl/pll_rst_seq.sv
// Reset sequencer between the PLL and the Qsys system: qualifies PLL lock,
// releases a registered active-low reset, and holds it after lock loss.
module pll_rst_seq #(
    parameter int LOCK_STABLE_CYCLES = 1000,
    parameter int RST_HOLD_CYCLES    = 16,
    parameter int LOSS_CNT_W         = 8
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst_n,
    input  logic                  pll_locked,
    output logic                  rst_n,
    output logic                  rst_done,
    output logic [LOSS_CNT_W-1:0] lock_loss_cnt,
    output logic [1:0]            seq_state
);

    typedef enum logic [1:0] {
        S_WAIT_LOCK = 2'd0,
        S_STABLE    = 2'd1,
        S_RUN       = 2'd2,
        S_HOLD      = 2'd3
    } state_t;

    localparam logic [15:0] STABLE_LAST = 16'(LOCK_STABLE_CYCLES - 1);
    localparam logic [15:0] HOLD_LAST   = 16'(RST_HOLD_CYCLES - 1);

    logic [1:0]  sync_pipe;
    logic        locked_s;
    state_t      state;
    logic [15:0] scnt;
    logic [15:0] hcnt;

    // pll_locked is asynchronous to sys_clk; only the second flop is used.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) sync_pipe <= 2'b00;
        else            sync_pipe <= {sync_pipe[0], pll_locked};
    end

    assign locked_s  = sync_pipe[1];
    assign seq_state = state;

    // rst_n is written alongside every state update so it always equals
    // (next_state == S_RUN) without a combinational path to the output.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state         <= S_WAIT_LOCK;
            scnt          <= 16'd0;
            hcnt          <= 16'd0;
            rst_n         <= 1'b0;
            rst_done      <= 1'b0;
            lock_loss_cnt <= '0;
        end else begin
            rst_n    <= 1'b0;
            rst_done <= 1'b0;
            case (state)
                S_WAIT_LOCK: begin
                    if (locked_s) begin
                        state <= S_STABLE;
                        scnt  <= 16'd0;
                    end
                end
                S_STABLE: begin
                    if (!locked_s) begin
                        state <= S_WAIT_LOCK;
                    end else if (scnt == STABLE_LAST) begin
                        state    <= S_RUN;
                        rst_n    <= 1'b1;
                        rst_done <= 1'b1;
                    end else begin
                        scnt <= scnt + 16'd1;
                    end
                end
                S_RUN: begin
                    if (!locked_s) begin
                        state <= S_HOLD;
                        hcnt  <= 16'd0;
                        if (!(&lock_loss_cnt))
                            lock_loss_cnt <= lock_loss_cnt + LOSS_CNT_W'(1);
                    end else begin
                        rst_n <= 1'b1;
                    end
                end
                S_HOLD: begin
                    // Lock is deliberately ignored until the hold time expires.
                    if (hcnt == HOLD_LAST) state <= S_WAIT_LOCK;
                    else                   hcnt  <= hcnt + 16'd1;
                end
                default: state <= S_WAIT_LOCK;
            endcase
        end
    end

endmodule
